// File: rtl/cci_mpf_csr_event_counters.sv
// MPF CSR event counters.
// Accumulates single-cycle event pulses from the VTP, VC MAP, WRO and PWRITE
// shims into saturating counters. Serves fixed two-cycle-latency reads for the
// CSR MMIO manager, with no backpressure, and supports per-counter clears.
// Index 12 returns the most recent page-table-walk address. Indices 13-15
// return zero.

module cci_mpf_csr_event_counters #(
    parameter int COUNTER_WIDTH = 48,
    parameter int CL_ADDR_WIDTH = 42
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     vtp_out_event_4kb_hit,
    input  logic                     vtp_out_event_4kb_miss,
    input  logic                     vtp_out_event_2mb_hit,
    input  logic                     vtp_out_event_2mb_miss,
    input  logic                     vtp_out_event_pt_walk_busy,
    input  logic                     vtp_out_event_failed_translation,
    input  logic                     vc_map_out_event_mapping_changed,
    input  logic                     wro_out_event_rr_conflict,
    input  logic                     wro_out_event_rw_conflict,
    input  logic                     wro_out_event_wr_conflict,
    input  logic                     wro_out_event_ww_conflict,
    input  logic                     pwrite_out_event_pwrite,
    input  logic [CL_ADDR_WIDTH-1:0] vtp_out_pt_walk_last_vaddr,

    input  logic                     rd_req_valid,
    input  logic [3:0]               rd_req_idx,
    input  logic [8:0]               rd_req_tid,
    output logic                     rd_rsp_valid,
    output logic [8:0]               rd_rsp_tid,
    output logic [63:0]              rd_rsp_data,

    input  logic                     clr_valid,
    input  logic [11:0]              clr_mask
);

    localparam int NUM_COUNTERS = 12;
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = {COUNTER_WIDTH{1'b1}};
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);
    localparam logic [3:0] VADDR_IDX = 4'd12;

    // Event vector. The bit position is the counter index seen by readers.
    logic [NUM_COUNTERS-1:0] event_s;

    assign event_s = {pwrite_out_event_pwrite,
                      wro_out_event_ww_conflict,
                      wro_out_event_wr_conflict,
                      wro_out_event_rw_conflict,
                      wro_out_event_rr_conflict,
                      vc_map_out_event_mapping_changed,
                      vtp_out_event_failed_translation,
                      vtp_out_event_pt_walk_busy,
                      vtp_out_event_2mb_miss,
                      vtp_out_event_2mb_hit,
                      vtp_out_event_4kb_miss,
                      vtp_out_event_4kb_hit};

    logic [COUNTER_WIDTH-1:0] cnt_q [NUM_COUNTERS];
    logic [COUNTER_WIDTH-1:0] cnt_d [NUM_COUNTERS];
    logic [CL_ADDR_WIDTH-1:0] vaddr_q;

    logic [63:0]              rd_mux_s;
    logic                     s1_valid_q;
    logic [8:0]               s1_tid_q;
    logic [63:0]              s1_data_q;

    logic                     rsp_valid_q;
    logic [8:0]               rsp_tid_q;
    logic [8:0]               rsp_tid_d;
    logic [63:0]              rsp_data_q;
    logic [63:0]              rsp_data_d;

    // Counter next state: a clear takes priority and then counts this cycle's
    // event, so that no event is lost. Otherwise the counter increments and
    // saturates at all-ones.
    always_comb begin
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clr_valid && clr_mask[i]) begin
                cnt_d[i] = event_s[i] ? CNT_ONE : '0;
            end else if (event_s[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Counter and walk-address state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                cnt_q[i] <= '0;
            end
            vaddr_q <= '0;
        end else begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            vaddr_q <= vtp_out_pt_walk_last_vaddr;
        end
    end

    // Read mux. It selects registered state only, so a read in cycle N sees
    // events from cycles before N and ignores a clear issued in cycle N.
    always_comb begin
        rd_mux_s = 64'd0;
        case (rd_req_idx)
            VADDR_IDX: rd_mux_s = 64'(vaddr_q);
            default: begin
                if (rd_req_idx < 4'(NUM_COUNTERS)) begin
                    rd_mux_s = 64'(cnt_q[rd_req_idx]);
                end else begin
                    rd_mux_s = 64'd0;
                end
            end
        endcase
    end

    // Read stage 1: capture the request and the selected value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_tid_q   <= 9'd0;
            s1_data_q  <= 64'd0;
        end else begin
            s1_valid_q <= rd_req_valid;
            s1_tid_q   <= rd_req_tid;
            s1_data_q  <= rd_mux_s;
        end
    end

    // Response next state: the fields hold their last value between responses.
    always_comb begin
        rsp_tid_d  = rsp_tid_q;
        rsp_data_d = rsp_data_q;
        if (s1_valid_q) begin
            rsp_tid_d  = s1_tid_q;
            rsp_data_d = s1_data_q;
        end else begin
            rsp_tid_d  = rsp_tid_q;
            rsp_data_d = rsp_data_q;
        end
    end

    // Read stage 2: the registered response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_tid_q   <= 9'd0;
            rsp_data_q  <= 64'd0;
        end else begin
            rsp_valid_q <= s1_valid_q;
            rsp_tid_q   <= rsp_tid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rd_rsp_valid = rsp_valid_q;
    assign rd_rsp_tid   = rsp_tid_q;
    assign rd_rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_cci_mpf_csr_event_counters.sv
// Bench for cci_mpf_csr_event_counters. It uses a table of event/read vectors
// and hand-written sequences. Expected responses go into a scoreboard queue
// when a read is driven. A monitor pops and compares each entry on the falling
// edge, and that comparison also checks the two-cycle latency.
// A second, 4-bit-wide instance makes counter saturation reachable in a few
// cycles.

module tb_cci_mpf_csr_event_counters;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] ev_s;
    logic        sat_ev_s;
    logic [41:0] vaddr_s;
    logic        rd_req_valid;
    logic [3:0]  rd_req_idx;
    logic [8:0]  rd_req_tid;
    logic        clr_valid;
    logic [11:0] clr_mask;
    logic        rd_rsp_valid;
    logic [8:0]  rd_rsp_tid;
    logic [63:0] rd_rsp_data;
    logic        sat_rsp_valid;
    logic [8:0]  sat_rsp_tid;
    logic [63:0] sat_rsp_data;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [8:0]  tid;
        logic [63:0] data;
        int          due;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        int          ev;
        int          n;
        logic [3:0]  idx;
        logic [8:0]  tid;
        logic [63:0] exp;
    } vec_t;
    vec_t tbl[10];

    cci_mpf_csr_event_counters #(.COUNTER_WIDTH(48), .CL_ADDR_WIDTH(42)) dut (
        .clk                              (clk),
        .reset                            (reset),
        .vtp_out_event_4kb_hit            (ev_s[0]),
        .vtp_out_event_4kb_miss           (ev_s[1]),
        .vtp_out_event_2mb_hit            (ev_s[2]),
        .vtp_out_event_2mb_miss           (ev_s[3]),
        .vtp_out_event_pt_walk_busy       (ev_s[4]),
        .vtp_out_event_failed_translation (ev_s[5]),
        .vc_map_out_event_mapping_changed (ev_s[6]),
        .wro_out_event_rr_conflict        (ev_s[7]),
        .wro_out_event_rw_conflict        (ev_s[8]),
        .wro_out_event_wr_conflict        (ev_s[9]),
        .wro_out_event_ww_conflict        (ev_s[10]),
        .pwrite_out_event_pwrite          (ev_s[11]),
        .vtp_out_pt_walk_last_vaddr       (vaddr_s),
        .rd_req_valid                     (rd_req_valid),
        .rd_req_idx                       (rd_req_idx),
        .rd_req_tid                       (rd_req_tid),
        .rd_rsp_valid                     (rd_rsp_valid),
        .rd_rsp_tid                       (rd_rsp_tid),
        .rd_rsp_data                      (rd_rsp_data),
        .clr_valid                        (clr_valid),
        .clr_mask                         (clr_mask)
    );

    cci_mpf_csr_event_counters #(.COUNTER_WIDTH(4), .CL_ADDR_WIDTH(42)) dut_sat (
        .clk                              (clk),
        .reset                            (reset),
        .vtp_out_event_4kb_hit            (1'b0),
        .vtp_out_event_4kb_miss           (1'b0),
        .vtp_out_event_2mb_hit            (sat_ev_s),
        .vtp_out_event_2mb_miss           (1'b0),
        .vtp_out_event_pt_walk_busy       (1'b0),
        .vtp_out_event_failed_translation (1'b0),
        .vc_map_out_event_mapping_changed (1'b0),
        .wro_out_event_rr_conflict        (1'b0),
        .wro_out_event_rw_conflict        (1'b0),
        .wro_out_event_wr_conflict        (1'b0),
        .wro_out_event_ww_conflict        (1'b0),
        .pwrite_out_event_pwrite          (1'b0),
        .vtp_out_pt_walk_last_vaddr       (42'd0),
        .rd_req_valid                     (rd_req_valid),
        .rd_req_idx                       (rd_req_idx),
        .rd_req_tid                       (rd_req_tid),
        .rd_rsp_valid                     (sat_rsp_valid),
        .rd_rsp_tid                       (sat_rsp_tid),
        .rd_rsp_data                      (sat_rsp_data),
        .clr_valid                        (1'b0),
        .clr_mask                         (12'd0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: every response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && rd_rsp_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_rsp", 64'(rd_rsp_valid), 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("rsp_tid", 64'(rd_rsp_tid), 64'(e.tid));
                chk("rsp_data", rd_rsp_data, e.data);
                chk("rsp_latency", 64'(cyc), 64'(e.due));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int idx, input int n);
        for (int i = 0; i < n; i++) begin
            ev_s[idx] = 1'b1;
            tick();
        end
        ev_s = 12'd0;
    endtask

    task automatic rd(input logic [3:0] idx, input logic [8:0] tid, input logic [63:0] exp, input bit push);
        rd_req_valid = 1'b1;
        rd_req_idx   = idx;
        rd_req_tid   = tid;
        if (push) sb_q.push_back('{tid: tid, data: exp, due: cyc + 2});
        tick();
        rd_req_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{ev: 0,  n: 5, idx: 4'd0,  tid: 9'h1A5, exp: 64'd5};
        tbl[1] = '{ev: 10, n: 3, idx: 4'd10, tid: 9'h0A3, exp: 64'd3};
        tbl[2] = '{ev: 0,  n: 2, idx: 4'd0,  tid: 9'h002, exp: 64'd7};
        tbl[3] = '{ev: 4,  n: 6, idx: 4'd4,  tid: 9'h104, exp: 64'd6};
        tbl[4] = '{ev: 11, n: 1, idx: 4'd11, tid: 9'h0B1, exp: 64'd1};
        tbl[5] = '{ev: 5,  n: 0, idx: 4'd5,  tid: 9'h055, exp: 64'd0};
        tbl[6] = '{ev: 6,  n: 4, idx: 4'd6,  tid: 9'h066, exp: 64'd4};
        tbl[7] = '{ev: 8,  n: 2, idx: 4'd8,  tid: 9'h088, exp: 64'd2};
        tbl[8] = '{ev: 7,  n: 9, idx: 4'd7,  tid: 9'h077, exp: 64'd9};
        tbl[9] = '{ev: 3,  n: 1, idx: 4'd3,  tid: 9'h1FF, exp: 64'd1};

        reset        = 1'b1;
        ev_s         = 12'd0;
        sat_ev_s     = 1'b0;
        vaddr_s      = 42'd0;
        rd_req_valid = 1'b0;
        rd_req_idx   = 4'd0;
        rd_req_tid   = 9'd0;
        clr_valid    = 1'b0;
        clr_mask     = 12'd0;
        tick();
        tick();
        @(negedge clk);
        chk("reset_valid", 64'(rd_rsp_valid), 64'd0);
        chk("reset_tid", 64'(rd_rsp_tid), 64'd0);
        chk("reset_data", rd_rsp_data, 64'd0);
        tick();
        reset = 1'b0;
        tick();

        // Pulse events from the table, then read each one back.
        for (int i = 0; i < 10; i++) begin
            pulse(tbl[i].ev, tbl[i].n);
            rd(tbl[i].idx, tbl[i].tid, tbl[i].exp, 1'b1);
        end

        // Back-to-back reads while event 1 is held high. Each read sees only
        // the earlier cycles.
        ev_s[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd(4'd1, 9'h140 + 9'(i), 64'(i), 1'b1);
        end
        ev_s = 12'd0;
        rd(4'd1, 9'h144, 64'd4, 1'b1);

        // Clear, event and read of counter 7 all in the same cycle.
        ev_s[7]   = 1'b1;
        clr_valid = 1'b1;
        clr_mask  = 12'h080;
        rd(4'd7, 9'h170, 64'd9, 1'b1);
        ev_s      = 12'd0;
        clr_valid = 1'b0;
        clr_mask  = 12'd0;
        rd(4'd7, 9'h171, 64'd1, 1'b1);
        rd(4'd8, 9'h180, 64'd2, 1'b1);

        // A clear with an empty mask has no effect. A clear without an event
        // loads zero.
        clr_valid = 1'b1;
        clr_mask  = 12'd0;
        tick();
        clr_mask  = 12'h011;
        tick();
        clr_valid = 1'b0;
        clr_mask  = 12'd0;
        rd(4'd0,  9'h0C0, 64'd0, 1'b1);
        rd(4'd4,  9'h0C4, 64'd0, 1'b1);
        rd(4'd10, 9'h0CA, 64'd3, 1'b1);

        // Walk address register and the out-of-range indices.
        vaddr_s = 42'h2_1234_5678;
        tick();
        rd(4'd12, 9'h0D2, 64'h2_1234_5678, 1'b1);
        clr_valid = 1'b1;
        clr_mask  = 12'hFFF;
        tick();
        clr_valid = 1'b0;
        clr_mask  = 12'd0;
        rd(4'd12, 9'h0D3, 64'h2_1234_5678, 1'b1);
        rd(4'd11, 9'h0DB, 64'd0, 1'b1);
        rd(4'd14, 9'h0DE, 64'd0, 1'b1);
        rd(4'd15, 9'h0DF, 64'd0, 1'b1);

        // Saturation on the narrow instance: 14, then three more events give
        // 15, the all-ones value.
        for (int i = 0; i < 14; i++) begin
            sat_ev_s = 1'b1;
            tick();
        end
        sat_ev_s = 1'b0;
        rd(4'd2, 9'h0E2, 64'd0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("sat_valid_a", 64'(sat_rsp_valid), 64'd1);
        chk("sat_tid_a", 64'(sat_rsp_tid), 64'h0E2);
        chk("sat_data_a", sat_rsp_data, 64'd14);
        for (int i = 0; i < 3; i++) begin
            sat_ev_s = 1'b1;
            tick();
        end
        sat_ev_s = 1'b0;
        rd(4'd2, 9'h0E3, 64'd0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("sat_valid_b", 64'(sat_rsp_valid), 64'd1);
        chk("sat_data_b", sat_rsp_data, 64'd15);

        // A reset issued one cycle after a read drops that read.
        tick();
        tick();
        tick();
        rd(4'd7, 9'h1EE, 64'd0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_valid", 64'(rd_rsp_valid), 64'd0);
        chk("rst_mid_tid", 64'(rd_rsp_tid), 64'd0);
        chk("rst_mid_data", rd_rsp_data, 64'd0);
        tick();
        @(negedge clk);
        chk("rst_mid_valid2", 64'(rd_rsp_valid), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        rd(4'd1,  9'h101, 64'd0, 1'b1);
        rd(4'd7,  9'h107, 64'd0, 1'b1);
        rd(4'd10, 9'h10A, 64'd0, 1'b1);
        rd(4'd12, 9'h10C, 64'h2_1234_5678, 1'b1);

        for (int i = 0; i < 5; i++) tick();
        chk("sb_drain", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cci_mpf_csr_event_counters.md
Name: cci_mpf_csr_event_counters

Overview:
- Consumer end of the MPF shim event wires: accumulates single-cycle event pulses from the VTP, VC MAP, WRO and PWRITE shims into saturating counters.
- Serves fixed-latency, non-backpressured read requests from the MPF CSR MMIO manager, plus per-counter clear requests.
- Sits between the shims' event outputs and the CSR manager's MMIO read-response path.

Parameters:
- COUNTER_WIDTH, 48: width of each event counter; values are zero-extended to 64 bits on read.
- CL_ADDR_WIDTH, 42: width of the cache-line address captured from the page-table walker.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- vtp_out_event_4kb_hit  in  1  event pulse, counter index 0
- vtp_out_event_4kb_miss  in  1  index 1
- vtp_out_event_2mb_hit  in  1  index 2
- vtp_out_event_2mb_miss  in  1  index 3
- vtp_out_event_pt_walk_busy  in  1  level signal; counts busy cycles, index 4
- vtp_out_event_failed_translation  in  1  index 5
- vc_map_out_event_mapping_changed  in  1  index 6
- wro_out_event_rr_conflict  in  1  index 7
- wro_out_event_rw_conflict  in  1  index 8
- wro_out_event_wr_conflict  in  1  index 9
- wro_out_event_ww_conflict  in  1  index 10
- pwrite_out_event_pwrite  in  1  index 11
- vtp_out_pt_walk_last_vaddr  in  CL_ADDR_WIDTH  last walked address; read at index 12
- rd_req_valid  in  1  read request strobe
- rd_req_idx  in  4  counter index
- rd_req_tid  in  9  MMIO transaction ID
- rd_rsp_valid  out  1  read response strobe
- rd_rsp_tid  out  9  echoed transaction ID
- rd_rsp_data  out  64  response data
- clr_valid  in  1  clear strobe
- clr_mask  in  12  one bit per counter, indices 0-11

Behaviour:
- Reset (async assert, sync deassert by the surrounding logic):
  - All counters clear to 0.
  - The index-12 address register clears to 0.
  - rd_rsp_valid, rd_rsp_tid and rd_rsp_data all reset to 0.
  - Any in-flight read is dropped and produces no response.
- Counting: on each clk edge where an event input is 1, the matching counter increments by 1.
  - pt_walk_busy counts every cycle it is high.
  - All counters update independently and in parallel.
- Saturation: a counter at all-ones (2^COUNTER_WIDTH-1) holds its value; there is no wrap.
- Clear: with clr_valid=1, every counter whose clr_mask bit is 1 loads (event_this_cycle ? 1 : 0). A same-cycle event is counted after the clear.
  - clr_valid with clr_mask=0 has no effect.
- Index-12 register: samples vtp_out_pt_walk_last_vaddr every cycle.
  - clr_mask has no bit for it and does not affect it.
  - Read data is the address zero-extended to 64 bits.
- Read pipeline, request in cycle N:
  - Stage 1 registers tid, valid, and the muxed counter value at the edge ending cycle N. The value includes events from cycles < N only.
  - Stage 2 registers the outputs. rd_rsp_valid is 1 in cycle N+2, for exactly one cycle.
  - Fixed 2-cycle latency; one request per cycle is sustained with no bubbles; responses return in request order.
- Read/clear interaction: a read in cycle N and a clear in cycle N return the pre-clear value.
- Out-of-range indices 13-15 return data 0 with a normal valid/tid response.
- Response fields:
  - rd_rsp_data[63:COUNTER_WIDTH] is always 0.
  - rd_rsp_data and rd_rsp_tid hold their last values when rd_rsp_valid=0.
- No backpressure: the MMIO path lacks flow control, so every accepted request produces exactly one response.

Test Plan:
- Reset, then pulse vtp_out_event_4kb_hit for 5 cycles and wro_out_event_ww_conflict for 3 cycles. Read idx 0 with tid 0x1A5 -> rd_rsp_valid two cycles later with tid 0x1A5 and data 5. Read idx 10 -> data 3.
- Hold event 1 high and issue a read of idx 1 every cycle for 4 cycles -> 4 consecutive responses with strictly increasing values, each tid matched in order.
- Force counter 2 to 2^48-2 (COUNTER_WIDTH=48), pulse vtp_out_event_2mb_hit 3 times -> read returns 0x0000_FFFF_FFFF_FFFF.
- Counter 7 at 9; in one cycle assert clr_valid with mask bit 7 set, assert the rr_conflict event, and issue a read of idx 7 -> that read returns 9; the next read returns 1. Counter 8, not in the mask, is unchanged.
- Drive last_vaddr=0x2_1234_5678 and read idx 12 -> data 0x2_1234_5678. Read idx 14 -> data 0 with valid asserted.
- Issue a read, then assert reset in cycle N+1 -> no rd_rsp_valid is seen, all outputs are 0, and counters read 0 after reset releases.
